pss_peak_detector: RTL and testbench

PSS_PEAK_DETECTOR -- requirements
Module: pss_peak_detector

---
 rtl/pss_pkg.sv | 10 +
 rtl/sliding_sum.sv | 33 +++
 rtl/pss_peak_detector.sv | 125 ++++++++++++
 tb/tb_pss_peak_detector.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pss_pkg.sv
// Shared types for the PSS peak detector: the detector state encoding.
package pss_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    HOLDOFF = 2'd2
  } pss_state_e;

endpackage

// File: rtl/sliding_sum.sv
// Moving-window sum: a LEN-deep shift register of accepted samples plus the
// running sum of its contents. The sample being accepted is not yet included.
module sliding_sum #(
  parameter int DW  = 24,
  parameter int LEN = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [DW-1:0]             data,
  input  logic                      valid,
  output logic [DW+$clog2(LEN)-1:0] sum
);

  localparam int SUM_W = DW + $clog2(LEN);

  logic [DW-1:0] win [LEN];

  // NOTE: the window memory is reset too, so the running sum stays exact
  // (oldest entry subtracted is a real sample or a known zero) after reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sum <= '0;
      for (int i = 0; i < LEN; i++) win[i] <= '0;
    end else if (valid) begin
      // NOTE: non-blocking, so every stage reads its pre-edge neighbour;
      // blocking assignments would collapse the shift register in one edge.
      sum    <= sum + SUM_W'(data) - SUM_W'(win[LEN-1]);
      win[0] <= data;
      for (int i = 1; i < LEN; i++) win[i] <= win[i-1];
    end
  end

endmodule

// File: rtl/pss_peak_detector.sv
// PSS correlation peak detector: threshold against a moving average, local
// maximum search, optional holdoff (enabled by macro PSS_PEAK_HOLDOFF_EN).
module pss_peak_detector
  import pss_pkg::*;
#(
  parameter int IN_DW           = 24,
  parameter int IDX_DW          = 16,
  parameter int WINDOW_LEN      = 8,
  parameter int DETECTION_SHIFT = 3,
  parameter int MIN_LEVEL       = 100,
  parameter int PEAK_WIN        = 4,
  parameter int HOLDOFF_LEN     = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [IN_DW-1:0]  s_axis_in_tdata,
  input  logic              s_axis_in_tvalid,
  output logic              peak_valid_o,
  output logic [IDX_DW-1:0] peak_idx_o,
  output logic [IN_DW-1:0]  peak_val_o
);

  localparam int LOG2_W  = $clog2(WINDOW_LEN);
  localparam int SUM_W   = IN_DW + LOG2_W;
  localparam int CMP_W   = SUM_W + DETECTION_SHIFT;
  localparam int FILL_W  = LOG2_W + 1;
  localparam int CNT_MAX = (PEAK_WIN > HOLDOFF_LEN) ? PEAK_WIN : HOLDOFF_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  pss_state_e        state;
  logic [SUM_W-1:0]  sum;
  logic [FILL_W-1:0] fill_cnt;
  logic [IDX_DW-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  logic [IN_DW-1:0]  cand_val;
  logic [IDX_DW-1:0] cand_idx;

  logic              filled;
  logic              trigger;
  logic              greater;
  logic [CMP_W-1:0]  in_scaled;
  logic [CMP_W-1:0]  sum_scaled;
  logic [IN_DW-1:0]  best_val;
  logic [IDX_DW-1:0] best_idx;

  sliding_sum #(
    .DW  (IN_DW),
    .LEN (WINDOW_LEN)
  ) u_sliding_sum (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .data     (s_axis_in_tdata),
    .valid    (s_axis_in_tvalid),
    .sum      (sum)
  );

  // NOTE: every output of this block is assigned on every path, so no latch.
  always_comb begin
    filled     = (fill_cnt == FILL_W'(WINDOW_LEN));
    in_scaled  = CMP_W'(s_axis_in_tdata) << LOG2_W;
    sum_scaled = CMP_W'(sum) << DETECTION_SHIFT;
    trigger    = filled && (s_axis_in_tdata > IN_DW'(MIN_LEVEL)) && (in_scaled > sum_scaled);
    greater    = (s_axis_in_tdata > cand_val);
    best_val   = greater ? s_axis_in_tdata : cand_val;
    best_idx   = greater ? idx : cand_idx;
  end

  // Everything advances only on accepted samples, so tvalid gaps are invisible.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= SEARCH;
      fill_cnt     <= '0;
      idx          <= '0;
      cnt          <= '0;
      cand_val     <= '0;
      cand_idx     <= '0;
      peak_valid_o <= 1'b0;
      peak_idx_o   <= '0;
      peak_val_o   <= '0;
    end else begin
      peak_valid_o <= 1'b0;
      if (s_axis_in_tvalid) begin
        idx <= idx + IDX_DW'(1);
        if (!filled) fill_cnt <= fill_cnt + FILL_W'(1);
        case (state)
          SEARCH: begin
            if (trigger) begin
              cand_val <= s_axis_in_tdata;
              cand_idx <= idx;
              cnt      <= '0;
              state    <= CONFIRM;
            end
          end
          CONFIRM: begin
            cand_val <= best_val;
            cand_idx <= best_idx;
            if (cnt == CNT_W'(PEAK_WIN - 1)) begin
              peak_valid_o <= 1'b1;
              peak_val_o   <= best_val;
              peak_idx_o   <= best_idx;
              cnt          <= '0;
`ifdef PSS_PEAK_HOLDOFF_EN
              state        <= HOLDOFF;
`else
              state        <= SEARCH;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          HOLDOFF: begin
            if (cnt == CNT_W'(HOLDOFF_LEN - 1)) begin
              cnt   <= '0;
              state <= SEARCH;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pss_peak_detector.sv
// Directed bench for pss_peak_detector: expected reports are queued when the
// stimulus is planned and matched against each peak_valid_o pulse.
module tb_pss_peak_detector;

  localparam int IN_DW  = 24;
  localparam int IDX_DW = 16;

  logic              clk_i            = 1'b0;
  logic              reset_ni         = 1'b0;
  logic [IN_DW-1:0]  s_axis_in_tdata  = '0;
  logic              s_axis_in_tvalid = 1'b0;
  logic              peak_valid_o;
  logic [IDX_DW-1:0] peak_idx_o;
  logic [IN_DW-1:0]  peak_val_o;

  typedef struct {
    int due;
    int idx;
    int val;
  } exp_t;

  typedef struct {
    int idx;
    int val;
  } spike_t;

  exp_t   exp_q[$];
  spike_t spikes[$];
  exp_t   mon_e;
  int     checks   = 0;
  int     failures = 0;
  int     pulses   = 0;
  int     n_exp    = 0;
  int     acc_idx  = -1;

  always #5 clk_i = ~clk_i;

  pss_peak_detector #(
    .IN_DW           (IN_DW),
    .IDX_DW          (IDX_DW),
    .WINDOW_LEN      (8),
    .DETECTION_SHIFT (3),
    .MIN_LEVEL       (100),
    .PEAK_WIN        (4),
    .HOLDOFF_LEN     (16)
  ) dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .s_axis_in_tdata  (s_axis_in_tdata),
    .s_axis_in_tvalid (s_axis_in_tvalid),
    .peak_valid_o     (peak_valid_o),
    .peak_idx_o       (peak_idx_o),
    .peak_val_o       (peak_val_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Scoreboard side: every pulse must match the oldest planned report,
  // including the index of the sample whose acceptance produced it.
  always @(negedge clk_i) begin
    if (reset_ni && peak_valid_o) begin
      pulses++;
      check("pulse_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("pulse_time", acc_idx, mon_e.due);
        check("peak_idx", peak_idx_o, mon_e.idx);
        check("peak_val", peak_val_o, mon_e.val);
      end
    end
  end

  task automatic expect_report(input int due, input int idx, input int val);
    exp_t e;
    e.due = due;
    e.idx = idx;
    e.val = val;
    exp_q.push_back(e);
    n_exp++;
  endtask

  task automatic add_spike(input int idx, input int val);
    spike_t s;
    s.idx = idx;
    s.val = val;
    spikes.push_back(s);
  endtask

  task automatic do_reset();
    s_axis_in_tvalid = 1'b0;
    reset_ni = 1'b0;
    #1;
    check("rst_valid", peak_valid_o, 0);
    check("rst_idx", peak_idx_o, 0);
    check("rst_val", peak_val_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    acc_idx  = -1;
    spikes.delete();
    exp_q.delete();
    pulses = 0;
    n_exp  = 0;
  endtask

  // Plays samples 0..n-1 (baseline 10 unless a spike is planned there).
  task automatic play(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int v;
      v = 10;
      foreach (spikes[k]) if (spikes[k].idx == i) v = spikes[k].val;
      if (gaps) begin
        s_axis_in_tvalid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk_i);
        #1;
      end
      s_axis_in_tdata  = IN_DW'(v);
      s_axis_in_tvalid = 1'b1;
      @(posedge clk_i);
      #1;
      acc_idx = i;
    end
    s_axis_in_tvalid = 1'b0;
  endtask

  task automatic finish_scenario(input string tag);
    repeat (3) @(posedge clk_i);
    #1;
    check({tag, "_reports"}, pulses, n_exp);
  endtask

  initial begin
    // Flat baseline never triggers.
    do_reset();
    play(200, 1'b0);
    finish_scenario("flat");

    // Single spike; outputs must hold after the pulse.
    do_reset();
    add_spike(20, 1000);
    expect_report(24, 20, 1000);
    play(60, 1'b0);
    finish_scenario("spike");
    check("hold_idx", peak_idx_o, 20);
    check("hold_val", peak_val_o, 1000);
    check("hold_valid", peak_valid_o, 0);

    // Larger sample inside the search window wins; a tie keeps the earlier.
    do_reset();
    add_spike(20, 500);
    add_spike(22, 900);
    add_spike(23, 900);
    expect_report(24, 22, 900);
    play(60, 1'b0);
    finish_scenario("local_max");

    // Second spike inside holdoff is suppressed only when holdoff is built in.
    do_reset();
    add_spike(20, 1000);
    add_spike(30, 1000);
    expect_report(24, 20, 1000);
`ifndef PSS_PEAK_HOLDOFF_EN
    expect_report(34, 30, 1000);
`endif
    play(60, 1'b0);
    finish_scenario("holdoff");

    // Spike before the window has filled is ignored.
    do_reset();
    add_spike(5, 1000);
    play(30, 1'b0);
    finish_scenario("unfilled");

    // Reset during CONFIRM discards the candidate and restarts numbering.
    do_reset();
    add_spike(20, 1000);
    play(22, 1'b0);
    finish_scenario("pre_reset");
    do_reset();
    add_spike(12, 1000);
    expect_report(16, 12, 1000);
    play(30, 1'b0);
    finish_scenario("post_reset");

    // Random tvalid gaps must not change the result.
    do_reset();
    add_spike(20, 1000);
    expect_report(24, 20, 1000);
    play(60, 1'b1);
    finish_scenario("gaps");
    check("gaps_idx", peak_idx_o, 20);
    check("gaps_val", peak_val_o, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
